// File: rtl/analyzer_pkg.sv
// Shared types and widths for the signal-analyzer control path.
// No logic beyond the judge compare helper; no latency or backpressure of its own.
// Default frame length lives here so top-level instances agree on it.
package analyzer_pkg;

    localparam int unsigned RES_W         = 16;
    localparam int unsigned SMP_W         = 8;
    localparam int unsigned DEF_FRAME_LEN = 1024;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        FFT_RUN,
        CALC_RUN,
        JUDGE,
        ERROR
    } state_t;

    // Unsigned, inclusive window on frequency and floor on amplitude; an
    // inverted window (fmin > fmax) can never be satisfied.
    function automatic logic judge_pass(
        input logic [RES_W-1:0] freq,
        input logic [RES_W-1:0] amp,
        input logic [RES_W-1:0] fmin,
        input logic [RES_W-1:0] fmax,
        input logic [RES_W-1:0] amin
    );
        return (freq >= fmin) && (freq <= fmax) && (amp >= amin);
    endfunction

endpackage

// File: rtl/analysis_watchdog.sv
// Wait-state watchdog: counts enabled cycles, cleared on request, flags expiry.
// Latency: expired asserts combinationally on the LIMIT-th enabled cycle after clear.
// Backpressure: none; the counter saturates at LIMIT-1 while held enabled.
module analysis_watchdog #(
    parameter int unsigned LIMIT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_limit;

    assign at_limit = (cnt_q == CNT_W'(LIMIT - 1));
    assign expired  = en && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/analysis_sequencer.sv
// Analysis run sequencer: capture one ADC frame, start FFT, start calculator, judge limits.
// Latency: buffer writes one cycle after the sample; results at calc_done+1, verdict at +2.
// Backpressure: none, ADC samples outside CAPTURE are dropped; ANALYZER_WATCHDOG_EN bounds the waits.
module analysis_sequencer
    import analyzer_pkg::*;
#(
    parameter int unsigned FRAME_LEN      = DEF_FRAME_LEN,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adc_valid,
    input  logic [SMP_W-1:0]  adc_data_in,
    input  logic              arm,
    input  logic              continuous,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [SMP_W-1:0]  buf_wr_data,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              calc_start,
    input  logic              calc_done,
    input  logic [RES_W-1:0]  calc_freq,
    input  logic [RES_W-1:0]  calc_amp,
    input  logic [RES_W-1:0]  freq_min,
    input  logic [RES_W-1:0]  freq_max,
    input  logic [RES_W-1:0]  amp_min,
    output logic [RES_W-1:0]  measured_frequency,
    output logic [RES_W-1:0]  measured_amplitude,
    output logic              pass_fail_flag,
    output logic              result_valid,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               frame_full_q, frame_full_d;
    logic               buf_wr_en_q, buf_wr_en_d;
    logic [ADDR_W-1:0]  buf_wr_addr_q, buf_wr_addr_d;
    logic [SMP_W-1:0]   buf_wr_data_q, buf_wr_data_d;
    logic               fft_start_q, fft_start_d;
    logic               calc_start_q, calc_start_d;
    logic [RES_W-1:0]   meas_freq_q, meas_freq_d;
    logic [RES_W-1:0]   meas_amp_q, meas_amp_d;
    logic               pass_q, pass_d;
    logic               result_valid_q, result_valid_d;

`ifdef ANALYZER_WATCHDOG_EN
    logic timeout_err_q, timeout_err_d;
    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    assign wd_en  = (state_q == FFT_RUN) || (state_q == CALC_RUN);
    assign wd_clr = (state_d != state_q);

    analysis_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_err        = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        frame_full_d   = frame_full_q;
        buf_wr_en_d    = 1'b0;
        buf_wr_addr_d  = buf_wr_addr_q;
        buf_wr_data_d  = buf_wr_data_q;
        fft_start_d    = 1'b0;
        calc_start_d   = 1'b0;
        meas_freq_d    = meas_freq_q;
        meas_amp_d     = meas_amp_q;
        pass_d         = pass_q;
        result_valid_d = 1'b0;
`ifdef ANALYZER_WATCHDOG_EN
        timeout_err_d  = timeout_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (arm || continuous) begin
                    state_d      = CAPTURE;
                    cnt_d        = '0;
                    frame_full_d = 1'b0;
                end
            end
            CAPTURE: begin
                // Linger one cycle after the last sample so fft_start trails the last write.
                if (frame_full_q) begin
                    state_d      = FFT_RUN;
                    fft_start_d  = 1'b1;
                    frame_full_d = 1'b0;
                end else if (adc_valid) begin
                    buf_wr_en_d   = 1'b1;
                    buf_wr_addr_d = cnt_q;
                    buf_wr_data_d = adc_data_in;
                    cnt_d         = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        frame_full_d = 1'b1;
                    end
                end
            end
            FFT_RUN: begin
                // The start-pulse cycle itself never accepts a done.
                if (fft_done && !fft_start_q) begin
                    state_d      = CALC_RUN;
                    calc_start_d = 1'b1;
                end
`ifdef ANALYZER_WATCHDOG_EN
                else if (wd_expired) begin
                    state_d       = ERROR;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            CALC_RUN: begin
                if (calc_done && !calc_start_q) begin
                    state_d     = JUDGE;
                    meas_freq_d = calc_freq;
                    meas_amp_d  = calc_amp;
                end
`ifdef ANALYZER_WATCHDOG_EN
                else if (wd_expired) begin
                    state_d       = ERROR;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            JUDGE: begin
                pass_d         = judge_pass(meas_freq_q, meas_amp_q, freq_min, freq_max, amp_min);
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
`ifdef ANALYZER_WATCHDOG_EN
            ERROR: begin
                if (arm) begin
                    state_d       = CAPTURE;
                    timeout_err_d = 1'b0;
                    cnt_d         = '0;
                    frame_full_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            frame_full_q   <= 1'b0;
            buf_wr_en_q    <= 1'b0;
            buf_wr_addr_q  <= '0;
            buf_wr_data_q  <= '0;
            fft_start_q    <= 1'b0;
            calc_start_q   <= 1'b0;
            meas_freq_q    <= '0;
            meas_amp_q     <= '0;
            pass_q         <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef ANALYZER_WATCHDOG_EN
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            frame_full_q   <= frame_full_d;
            buf_wr_en_q    <= buf_wr_en_d;
            buf_wr_addr_q  <= buf_wr_addr_d;
            buf_wr_data_q  <= buf_wr_data_d;
            fft_start_q    <= fft_start_d;
            calc_start_q   <= calc_start_d;
            meas_freq_q    <= meas_freq_d;
            meas_amp_q     <= meas_amp_d;
            pass_q         <= pass_d;
            result_valid_q <= result_valid_d;
`ifdef ANALYZER_WATCHDOG_EN
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign buf_wr_en          = buf_wr_en_q;
    assign buf_wr_addr        = buf_wr_addr_q;
    assign buf_wr_data        = buf_wr_data_q;
    assign fft_start          = fft_start_q;
    assign calc_start         = calc_start_q;
    assign measured_frequency = meas_freq_q;
    assign measured_amplitude = meas_amp_q;
    assign pass_fail_flag     = pass_q;
    assign result_valid       = result_valid_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_analysis_sequencer.sv
// Directed bench for analysis_sequencer with an 8-sample frame and a 16-cycle watchdog.
module tb_analysis_sequencer;

    logic        clk;
    logic        rst_n;
    logic        adc_valid;
    logic [7:0]  adc_data_in;
    logic        arm;
    logic        continuous;
    logic        buf_wr_en;
    logic [2:0]  buf_wr_addr;
    logic [7:0]  buf_wr_data;
    logic        fft_start;
    logic        fft_done;
    logic        calc_start;
    logic        calc_done;
    logic [15:0] calc_freq;
    logic [15:0] calc_amp;
    logic [15:0] freq_min;
    logic [15:0] freq_max;
    logic [15:0] amp_min;
    logic [15:0] measured_frequency;
    logic [15:0] measured_amplitude;
    logic        pass_fail_flag;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    int fft_start_cnt  = 0;
    int calc_start_cnt = 0;
    int rv_cnt         = 0;
    int f0, c0, r0;
    logic [7:0] exp_data;

    analysis_sequencer #(
        .FRAME_LEN      (8),
        .ADDR_W         (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .adc_valid          (adc_valid),
        .adc_data_in        (adc_data_in),
        .arm                (arm),
        .continuous         (continuous),
        .buf_wr_en          (buf_wr_en),
        .buf_wr_addr        (buf_wr_addr),
        .buf_wr_data        (buf_wr_data),
        .fft_start          (fft_start),
        .fft_done           (fft_done),
        .calc_start         (calc_start),
        .calc_done          (calc_done),
        .calc_freq          (calc_freq),
        .calc_amp           (calc_amp),
        .freq_min           (freq_min),
        .freq_max           (freq_max),
        .amp_min            (amp_min),
        .measured_frequency (measured_frequency),
        .measured_amplitude (measured_amplitude),
        .pass_fail_flag     (pass_fail_flag),
        .result_valid       (result_valid),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fft_start)    fft_start_cnt++;
        if (calc_start)   calc_start_cnt++;
        if (result_valid) rv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts on the first CAPTURE cycle and ends at calc_done+2 (back in IDLE).
    task automatic run_body(input logic [15:0] f, input logic [15:0] a,
                            input logic exp_pass, input string tag);
        for (int k = 0; k < 8; k++) begin
            adc_valid   = 1'b1;
            adc_data_in = 8'(k * 5);
            tick();
        end
        adc_valid = 1'b0;
        check({tag, "_last_addr"}, buf_wr_addr, 7);
        tick();
        check({tag, "_fft_start"}, fft_start, 1);
        tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check({tag, "_calc_start"}, calc_start, 1);
        tick();
        calc_freq = f;
        calc_amp  = a;
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        check({tag, "_meas_freq"}, measured_frequency, f);
        check({tag, "_meas_amp"}, measured_amplitude, a);
        tick();
        check({tag, "_result_valid"}, result_valid, 1);
        check({tag, "_pass"}, pass_fail_flag, exp_pass);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic run_frame(input logic [15:0] f, input logic [15:0] a,
                             input logic exp_pass, input string tag);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        run_body(f, a, exp_pass, tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        adc_valid   = 1'b0;
        adc_data_in = '0;
        arm         = 1'b0;
        continuous  = 1'b0;
        fft_done    = 1'b0;
        calc_done   = 1'b0;
        calc_freq   = '0;
        calc_amp    = '0;
        freq_min    = 16'd100;
        freq_max    = 16'd200;
        amp_min     = 16'd50;
        repeat (3) tick();

        check("rst_busy", busy, 0);
        check("rst_wr_en", buf_wr_en, 0);
        check("rst_fft_start", fft_start, 0);
        check("rst_calc_start", calc_start, 0);
        check("rst_pass", pass_fail_flag, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_meas_freq", measured_frequency, 0);
        check("rst_timeout", timeout_err, 0);

        rst_n = 1'b1;
        tick();

        // Frame capture with a gap cycle, stray fft_done during capture, arm during FFT.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_busy", busy, 1);
        f0 = fft_start_cnt;
        c0 = calc_start_cnt;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                adc_valid = 1'b0;
                fft_done  = 1'b1;
                tick();
                fft_done = 1'b0;
                check("cap_gap_no_wr", buf_wr_en, 0);
            end
            adc_valid   = 1'b1;
            adc_data_in = 8'(k - 4);
            exp_data    = 8'(k - 4);
            tick();
            check("cap_wr_en", buf_wr_en, 1);
            check("cap_wr_addr", buf_wr_addr, k);
            check("cap_wr_data", buf_wr_data, exp_data);
        end
        adc_valid = 1'b0;
        check("cap_no_early_fft_start", fft_start, 0);
        tick();
        check("cap_fft_start", fft_start, 1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("fft_start_single", fft_start, 0);
        check("fft_busy", busy, 1);
        repeat (2) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check("calc_start", calc_start, 1);
        calc_freq = 16'd999;
        calc_amp  = 16'd999;
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        tick();
        check("early_calc_done_ignored", measured_frequency, 0);
        check("early_calc_done_no_rv", result_valid, 0);
        calc_freq = 16'd150;
        calc_amp  = 16'd50;
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        check("pass_meas_freq", measured_frequency, 150);
        check("pass_meas_amp", measured_amplitude, 50);
        check("pass_rv_not_yet", result_valid, 0);
        tick();
        check("pass_rv", result_valid, 1);
        check("pass_flag", pass_fail_flag, 1);
        check("pass_idle", busy, 0);
        check("one_fft_start", fft_start_cnt - f0, 1);
        check("one_calc_start", calc_start_cnt - c0, 1);
        tick();
        check("rv_one_cycle", result_valid, 0);
        check("arm_in_fft_not_queued", busy, 0);
        check("pass_flag_held", pass_fail_flag, 1);

        // Judge boundaries.
        run_frame(16'd201, 16'd80, 1'b0, "fail_freq_hi");
        run_frame(16'd200, 16'd50, 1'b1, "pass_edges");
        run_frame(16'd100, 16'd49, 1'b0, "fail_amp_lo");
        run_frame(16'd100, 16'd50, 1'b1, "pass_fmin_edge");
        freq_min = 16'd300;
        freq_max = 16'd200;
        run_frame(16'd250, 16'd80, 1'b0, "fail_inverted");
        freq_min = 16'd100;
        freq_max = 16'd200;

        // Continuous: two frames back to back, dropped during the second capture.
        tick();
        r0 = rv_cnt;
        continuous = 1'b1;
        tick();
        check("cont_capture1", busy, 1);
        run_body(16'd150, 16'd60, 1'b1, "cont_f1");
        tick();
        check("cont_rearm", busy, 1);
        continuous = 1'b0;
        run_body(16'd250, 16'd60, 1'b0, "cont_f2");
        tick();
        check("cont_stays_idle", busy, 0);
        check("cont_two_results", rv_cnt - r0, 2);

        // Asynchronous reset in CALC_RUN.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < 8; k++) begin
            adc_valid   = 1'b1;
            adc_data_in = 8'(k);
            tick();
        end
        adc_valid = 1'b0;
        repeat (2) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        tick();
        f0 = fft_start_cnt;
        c0 = calc_start_cnt;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_meas_freq", measured_frequency, 0);
        check("mrst_meas_amp", measured_amplitude, 0);
        check("mrst_wr_addr", buf_wr_addr, 0);
        check("mrst_pass", pass_fail_flag, 0);
        #2;
        rst_n = 1'b1;
        repeat (5) tick();
        check("mrst_stays_idle", busy, 0);
        check("mrst_no_fft_start", fft_start_cnt - f0, 0);
        check("mrst_no_calc_start", calc_start_cnt - c0, 0);

        // Stalled FFT.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 0; k < 8; k++) begin
            adc_valid   = 1'b1;
            adc_data_in = 8'(k);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        check("wd_fft_start", fft_start, 1);
`ifdef ANALYZER_WATCHDOG_EN
        repeat (15) tick();
        check("wd_not_yet", timeout_err, 0);
        tick();
        check("wd_timeout", timeout_err, 1);
        check("wd_error_busy", busy, 1);
        continuous = 1'b1;
        tick();
        continuous = 1'b0;
        check("wd_cont_no_exit", timeout_err, 1);
        check("wd_results_held", measured_frequency, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("wd_arm_clears", timeout_err, 0);
        check("wd_arm_busy", busy, 1);
        adc_valid   = 1'b1;
        adc_data_in = 8'h5a;
        tick();
        adc_valid = 1'b0;
        check("wd_restart_wr_en", buf_wr_en, 1);
        check("wd_restart_addr", buf_wr_addr, 0);
        check("wd_restart_data", buf_wr_data, 8'h5a);
`else
        repeat (20) tick();
        check("nowd_no_timeout", timeout_err, 0);
        check("nowd_still_waiting", busy, 1);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        check("nowd_calc_start", calc_start, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
